// File: rtl/cond_logic_pipe.sv
// cond_logic_pipe: Execute-stage conditional-execution unit for the pipelined ARM datapath.
// Holds the NZCV flag register, evaluates Cond, gates PCSrc/RegWrite/MemWrite and
// tracks one pending multi-cycle (MUL/DIV) instruction.
// Optional build macro: COND_PERF_CNT_EN enables the saturating SquashCnt counter.
module cond_logic_pipe #(
   parameter int unsigned FLAGW_W = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               CLK,
   input  logic               RESETn,
   input  logic               Valid,
   input  logic               Stall,
   input  logic               Flush,
   input  logic               MCycle,
   input  logic               Done,
   input  logic               PCS,
   input  logic               RegW,
   input  logic               NoWrite,
   input  logic               MemW,
   input  logic [FLAGW_W-1:0] FlagW,
   input  logic [3:0]         Cond,
   input  logic [3:0]         ALUFlags,
   output logic               PCSrc,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic               CondEx,
   output logic               Busy,
   output logic [3:0]         Flags,
   output logic [CNT_W-1:0]   SquashCnt
);

   localparam int unsigned GRP_W = 4 / FLAGW_W;

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t             state, nextState;
   logic               condPass;
   logic               issue;
   logic               mcStart;
   logic               mcDone;
   logic [FLAGW_W-1:0] flagWrEn;
   logic [3:0]         flagsNext;
   logic               pcsL, regWL, noWriteL, memWL;
   logic [FLAGW_W-1:0] flagWL;

   // Issue qualification; reset also forces the gated outputs low immediately
   assign issue   = RESETn & Valid & ~Stall & ~Flush & (state == S_IDLE);
   assign mcStart = issue & MCycle & condPass;
   assign mcDone  = (state == S_WAIT) & Done & ~Flush;

   // ARM condition decode against registered {N,Z,C,V}
   always_comb begin
      condPass = 1'b0;
      case (Cond)
         4'h0: condPass = Flags[2];
         4'h1: condPass = ~Flags[2];
         4'h2: condPass = Flags[1];
         4'h3: condPass = ~Flags[1];
         4'h4: condPass = Flags[3];
         4'h5: condPass = ~Flags[3];
         4'h6: condPass = Flags[0];
         4'h7: condPass = ~Flags[0];
         4'h8: condPass = Flags[1] & ~Flags[2];
         4'h9: condPass = ~Flags[1] | Flags[2];
         4'hA: condPass = (Flags[3] == Flags[0]);
         4'hB: condPass = (Flags[3] != Flags[0]);
         4'hC: condPass = ~Flags[2] & (Flags[3] == Flags[0]);
         4'hD: condPass = Flags[2] | (Flags[3] != Flags[0]);
         4'hE: condPass = 1'b1;
         default: condPass = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) state <= S_IDLE;
      else         state <= nextState;
   end

   // Next-state: enter WAIT on a passing multi-cycle issue, leave on Done or Flush
   always_comb begin
      nextState = state;
      case (state)
         S_IDLE: if (mcStart)       nextState = S_WAIT;
         S_WAIT: if (Flush | Done)  nextState = S_IDLE;
         default:                   nextState = S_IDLE;
      endcase
   end

   // Output decode: single-cycle gating in IDLE, latched controls on Done in WAIT
   always_comb begin
      PCSrc    = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      CondEx   = 1'b0;
      Busy     = 1'b0;
      flagWrEn = '0;
      case (state)
         S_IDLE: begin
            CondEx = issue & condPass;
            if (issue & ~MCycle & condPass) begin
               PCSrc    = PCS;
               RegWrite = RegW & ~NoWrite;
               MemWrite = MemW;
               flagWrEn = FlagW;
            end
         end
         S_WAIT: begin
            Busy = 1'b1;
            if (mcDone) begin
               PCSrc    = pcsL;
               RegWrite = regWL & ~noWriteL;
               MemWrite = memWL;
               flagWrEn = flagWL;
            end
         end
         default: ;
      endcase
   end

   // Per-bit flag mux; group g covers bits [(g+1)*GRP_W-1 : g*GRP_W]
   for (genvar b = 0; b < 4; b++) begin : gFlagBit
      assign flagsNext[b] = flagWrEn[b / GRP_W] ? ALUFlags[b] : Flags[b];
   end

   // Flag register
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) Flags <= 4'b0000;
      else         Flags <= flagsNext;
   end

   // Capture controls of a multi-cycle instruction at issue
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         pcsL     <= 1'b0;
         regWL    <= 1'b0;
         noWriteL <= 1'b0;
         memWL    <= 1'b0;
         flagWL   <= '0;
      end else if (mcStart) begin
         pcsL     <= PCS;
         regWL    <= RegW;
         noWriteL <= NoWrite;
         memWL    <= MemW;
         flagWL   <= FlagW;
      end
   end

`ifdef COND_PERF_CNT_EN
   // Saturating count of issued instructions whose condition failed
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn)
         SquashCnt <= '0;
      else if (issue & ~condPass & ~(&SquashCnt))
         SquashCnt <= SquashCnt + CNT_W'(1);
   end
`else
   assign SquashCnt = '0;
`endif

endmodule

// File: tb/tb_cond_logic_pipe.sv
// tb_cond_logic_pipe: directed vector table plus multi-cycle / flush / reset sequences.
module tb_cond_logic_pipe;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   logic        CLK, RESETn;
   logic        Valid, Stall, Flush, MCycle, Done;
   logic        PCS, RegW, NoWrite, MemW;
   logic [1:0]  FlagW;
   logic [3:0]  Cond, ALUFlags;
   logic        PCSrc, RegWrite, MemWrite, CondEx, Busy;
   logic [3:0]  Flags;
   logic [15:0] SquashCnt;

   int total = 0;
   int bad   = 0;
   int sqExp = 0;

   cond_logic_pipe #(.FLAGW_W(2), .CNT_W(16)) dut (
      .CLK(CLK), .RESETn(RESETn), .Valid(Valid), .Stall(Stall), .Flush(Flush),
      .MCycle(MCycle), .Done(Done), .PCS(PCS), .RegW(RegW), .NoWrite(NoWrite),
      .MemW(MemW), .FlagW(FlagW), .Cond(Cond), .ALUFlags(ALUFlags),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
      .Busy(Busy), .Flags(Flags), .SquashCnt(SquashCnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       valid, stall, flush;
      logic [1:0] flagW;
      logic [3:0] cond, alu;
      logic       pcs, regW, noWrite, memW;
      logic       eCondEx, ePcSrc, eRegWrite, eMemWrite;
      logic [3:0] eFlags;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int sqWant();
`ifdef COND_PERF_CNT_EN
      return sqExp;
`else
      return 0;
`endif
   endfunction

   task automatic idleIn();
      Valid = F; Stall = F; Flush = F; MCycle = F; Done = F;
      PCS = F; RegW = F; NoWrite = F; MemW = F;
      FlagW = 2'b00; Cond = 4'hE; ALUFlags = 4'h0;
   endtask

   task automatic chkOut(input string nm, input logic p, input logic r, input logic m, input logic c);
      chk({nm, ".PCSrc"},    32'(PCSrc),    32'(p));
      chk({nm, ".RegWrite"}, 32'(RegWrite), 32'(r));
      chk({nm, ".MemWrite"}, 32'(MemWrite), 32'(m));
      chk({nm, ".CondEx"},   32'(CondEx),   32'(c));
   endtask

   // Issue a multi-cycle instruction (Cond=AL, RegW, FlagW=11) and enter WAIT
   task automatic startMul(input string nm);
      @(negedge CLK);
      idleIn();
      Valid = T; MCycle = T; RegW = T; FlagW = 2'b11; Cond = 4'hE; ALUFlags = 4'hF;
      #1 chkOut({nm, ".issue"}, F, F, F, T);
      chk({nm, ".issueBusy"}, 32'(Busy), 0);
      @(posedge CLK); #1;
      chk({nm, ".busy"}, 32'(Busy), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            vld st fl flagW  cond  alu    pcs regW noW memW  cEx pcS rW  mW  flags
      vecs[0]  = '{T, F, F, 2'b00, 4'hE, 4'h0, F, F, F, T,   T, F, F, T, 4'b0000}; // STR
      vecs[1]  = '{T, F, F, 2'b11, 4'hE, 4'h4, F, T, F, F,   T, F, T, F, 4'b0100}; // ADDS
      vecs[2]  = '{T, F, F, 2'b00, 4'h0, 4'h0, F, T, F, F,   T, F, T, F, 4'b0100}; // ADDEQ
      vecs[3]  = '{T, F, F, 2'b01, 4'hE, 4'hB, F, F, F, F,   T, F, F, F, 4'b0111}; // C,V only
      vecs[4]  = '{T, F, F, 2'b11, 4'h1, 4'hF, F, T, F, F,   F, F, F, F, 4'b0111}; // NE fails
      vecs[5]  = '{T, F, F, 2'b00, 4'hF, 4'h0, T, F, F, F,   F, F, F, F, 4'b0111}; // 1111 never
      vecs[6]  = '{T, T, F, 2'b11, 4'hE, 4'h0, F, T, F, F,   F, F, F, F, 4'b0111}; // stall
      vecs[7]  = '{T, T, T, 2'b11, 4'hE, 4'h0, F, T, F, F,   F, F, F, F, 4'b0111}; // flush+stall
      vecs[8]  = '{F, F, F, 2'b11, 4'hE, 4'h0, F, T, F, F,   F, F, F, F, 4'b0111}; // not valid
      vecs[9]  = '{T, F, F, 2'b11, 4'hE, 4'h8, T, T, T, F,   T, T, F, F, 4'b1000}; // CMP-like, PC
      vecs[10] = '{T, F, F, 2'b00, 4'h4, 4'h0, F, T, F, F,   T, F, T, F, 4'b1000}; // MI
      vecs[11] = '{T, F, F, 2'b00, 4'hA, 4'h0, F, T, F, F,   F, F, F, F, 4'b1000}; // GE fails
      vecs[12] = '{T, F, F, 2'b00, 4'hB, 4'h0, F, F, F, T,   T, F, F, T, 4'b1000}; // LT
      vecs[13] = '{T, F, F, 2'b10, 4'hE, 4'h6, F, F, F, F,   T, F, F, F, 4'b0100}; // N,Z only
      vecs[14] = '{T, F, F, 2'b00, 4'h1, 4'h0, F, T, F, F,   F, F, F, F, 4'b0100}; // NE fails
      vecs[15] = '{T, F, F, 2'b11, 4'hE, 4'h2, F, F, F, F,   T, F, F, F, 4'b0010};
      vecs[16] = '{T, F, F, 2'b00, 4'h8, 4'h0, F, T, F, F,   T, F, T, F, 4'b0010}; // HI
      vecs[17] = '{T, F, F, 2'b00, 4'h9, 4'h0, F, T, F, F,   F, F, F, F, 4'b0010}; // LS fails
      vecs[18] = '{T, F, F, 2'b00, 4'h2, 4'h0, F, F, F, T,   T, F, F, T, 4'b0010}; // CS

      idleIn();
      RESETn = 1'b0;
      #3;
      chkOut("reset", F, F, F, F);
      chk("reset.Flags", 32'(Flags), 0);
      chk("reset.Busy", 32'(Busy), 0);
      chk("reset.SquashCnt", 32'(SquashCnt), 0);
      @(negedge CLK);
      RESETn = 1'b1;

      for (int i = 0; i < 19; i++) begin
         @(negedge CLK);
         idleIn();
         Valid = vecs[i].valid; Stall = vecs[i].stall; Flush = vecs[i].flush;
         FlagW = vecs[i].flagW; Cond = vecs[i].cond; ALUFlags = vecs[i].alu;
         PCS = vecs[i].pcs; RegW = vecs[i].regW; NoWrite = vecs[i].noWrite; MemW = vecs[i].memW;
         #1;
         chkOut($sformatf("vec%0d", i), vecs[i].ePcSrc, vecs[i].eRegWrite,
                vecs[i].eMemWrite, vecs[i].eCondEx);
         if (vecs[i].valid && !vecs[i].stall && !vecs[i].flush && !vecs[i].eCondEx) sqExp++;
         @(posedge CLK); #1;
         chk($sformatf("vec%0d.Flags", i), 32'(Flags), 32'(vecs[i].eFlags));
         chk($sformatf("vec%0d.Busy", i), 32'(Busy), 0);
         chk($sformatf("vec%0d.SquashCnt", i), 32'(SquashCnt), 32'(sqWant()));
      end

      // MUL: three WAIT cycles, Done on the third; Valid ignored while waiting
      startMul("mul");
      for (int w = 0; w < 3; w++) begin
         @(negedge CLK);
         idleIn();
         Valid = T; Cond = 4'hE; MemW = T;
         if (w == 2) begin Done = T; ALUFlags = 4'h9; end
         #1;
         chkOut($sformatf("mulw%0d", w), F, (w == 2), F, F);
         chk($sformatf("mulw%0d.Busy", w), 32'(Busy), 1);
         @(posedge CLK); #1;
      end
      chk("mul.BusyAfter", 32'(Busy), 0);
      chk("mul.Flags", 32'(Flags), 4'h9);

      // Done while IDLE is ignored
      @(negedge CLK);
      idleIn();
      Done = T; ALUFlags = 4'h0;
      #1 chkOut("doneIdle", F, F, F, F);
      @(posedge CLK); #1;
      chk("doneIdle.Flags", 32'(Flags), 4'h9);

      // Flush in WAIT, then a late Done
      startMul("flush");
      @(negedge CLK);
      idleIn();
      Flush = T; ALUFlags = 4'h0;
      #1 chkOut("flush.w", F, F, F, F);
      @(posedge CLK); #1;
      chk("flush.Busy", 32'(Busy), 0);
      @(negedge CLK);
      idleIn();
      Done = T; ALUFlags = 4'h0;
      #1 chkOut("flush.done", F, F, F, F);
      @(posedge CLK); #1;
      chk("flush.BusyDone", 32'(Busy), 0);
      chk("flush.Flags", 32'(Flags), 4'h9);

      // Flush together with Done
      startMul("flushDone");
      @(negedge CLK);
      idleIn();
      Flush = T; Done = T; ALUFlags = 4'h0;
      #1 chkOut("flushDone.w", F, F, F, F);
      @(posedge CLK); #1;
      chk("flushDone.Busy", 32'(Busy), 0);
      chk("flushDone.Flags", 32'(Flags), 4'h9);

      // Multi-cycle with failing condition (EQ, Z=0): stays IDLE, counts as squash
      @(negedge CLK);
      idleIn();
      Valid = T; MCycle = T; RegW = T; FlagW = 2'b11; Cond = 4'h0; ALUFlags = 4'hF;
      #1 chkOut("mulFail", F, F, F, F);
      sqExp++;
      @(posedge CLK); #1;
      chk("mulFail.Busy", 32'(Busy), 0);
      chk("mulFail.Flags", 32'(Flags), 4'h9);
      chk("mulFail.SquashCnt", 32'(SquashCnt), 32'(sqWant()));

      // Reset asserted mid-WAIT clears everything at once
      startMul("rst");
      @(negedge CLK);
      idleIn();
      Valid = T; Cond = 4'hE; MemW = T; Done = T; ALUFlags = 4'hF;
      RESETn = 1'b0;
      #1;
      chkOut("rst.mid", F, F, F, F);
      chk("rst.Flags", 32'(Flags), 0);
      chk("rst.Busy", 32'(Busy), 0);
      chk("rst.SquashCnt", 32'(SquashCnt), 0);
      @(negedge CLK);
      idleIn();
      RESETn = 1'b1;
      Done = T; ALUFlags = 4'hF;
      #1 chkOut("rst.after", F, F, F, F);
      @(posedge CLK); #1;
      chk("rst.afterFlags", 32'(Flags), 0);
      chk("rst.afterBusy", 32'(Busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
